// File: rtl/fsm.sv
// rtl/fsm.sv - three-state cyclic next-state block with registered output; FSM_ERR_EN adds registered illegal-code flag err
module fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic [1:0] a,
  output logic [1:0] y
`ifdef FSM_ERR_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [1:0] {
    S0    = 2'd0,
    S1    = 2'd1,
    S2    = 2'd2,
    S_ILL = 2'd3
  } state_e;

  state_e cur_state;
  state_e y_d;
  state_e y_q;

  assign cur_state = state_e'(a);

  // Successor of the externally supplied state; only the enable of the current state is consulted.
  always_comb begin
    y_d = S0;
    case (cur_state)
      S0:      y_d = i0 ? S1 : S0;
      S1:      y_d = i1 ? S2 : S1;
      S2:      y_d = i2 ? S0 : S2;
      default: y_d = S0;  // illegal code recovers to S0
    endcase
  end

`ifdef FSM_ERR_EN
  logic err_d;
  logic err_q;

  // Flag a sampled illegal state code; cleared again by the next legal code.
  always_comb begin
    err_d = (cur_state == S_ILL);
  end
`endif

  // Register the successor state (and the error flag when enabled); reset forces S0.
  always_ff @(posedge clock) begin
    if (reset) begin
      y_q   <= S0;
`ifdef FSM_ERR_EN
      err_q <= 1'b0;
`endif
    end else begin
      y_q   <= y_d;
`ifdef FSM_ERR_EN
      err_q <= err_d;
`endif
    end
  end

  assign y = y_q;
`ifdef FSM_ERR_EN
  assign err = err_q;
`endif

endmodule

// File: tb/tb_fsm.sv
// tb/tb_fsm.sv - directed self-checking bench for fsm
module tb_fsm;

  logic       clock;
  logic       reset;
  logic       i0;
  logic       i1;
  logic       i2;
  logic [1:0] a;
  logic [1:0] a_drv;
  logic [1:0] a_reg;
  logic       loop_en;
  logic [1:0] y;
`ifdef FSM_ERR_EN
  logic       err;
`endif

  int n_vec;
  int n_err;

  fsm dut (
    .clock (clock),
    .reset (reset),
    .i0    (i0),
    .i1    (i1),
    .i2    (i2),
    .a     (a),
    .y     (y)
`ifdef FSM_ERR_EN
    ,
    .err   (err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External state register closing the loop a <= y, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) a_reg <= 2'd0;
    else       a_reg <= y;
  end

  assign a = loop_en ? a_reg : a_drv;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] loop_exp [10];
    n_vec   = 0;
    n_err   = 0;
    loop_en = 1'b0;
    reset   = 1'b1;
    a_drv   = 2'd2;
    {i2, i1, i0} = 3'b111;

    // Reset hold with inputs that would otherwise move the state.
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("reset_hold_%0d", k), y, 2'd0);
`ifdef FSM_ERR_EN
      chk($sformatf("reset_hold_err_%0d", k), {1'b0, err}, 2'd0);
`endif
    end

    // Reset with illegal code present: y and err stay 0.
    a_drv = 2'd3;
    tick();
    chk("reset_illegal_y", y, 2'd0);
`ifdef FSM_ERR_EN
    chk("reset_illegal_err", {1'b0, err}, 2'd0);
`endif

    // Free-running loop: 2-cycle cadence 1,1,2,2,0,0,1,1,2,2.
    loop_exp = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    loop_en  = 1'b1;
    reset    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("loop_%0d", k), y, loop_exp[k]);
    end

    // Mid-run reset while y=2, then resume from S0.
    reset = 1'b1;
    tick();
    chk("midrun_reset", y, 2'd0);
    reset = 1'b0;
    tick();
    chk("resume_0", y, 2'd1);
    tick();
    chk("resume_1", y, 2'd1);
    tick();
    chk("resume_2", y, 2'd2);

    // Directed next-state vectors.
    loop_en = 1'b0;
    a_drv = 2'd1; {i2, i1, i0} = 3'b101;
    tick();
    chk("stall_s1", y, 2'd1);
    i1 = 1'b1;
    tick();
    chk("adv_s1", y, 2'd2);

    a_drv = 2'd0; {i2, i1, i0} = 3'b001;
    tick();
    chk("dc_s0_adv", y, 2'd1);
    a_drv = 2'd0; {i2, i1, i0} = 3'b110;
    tick();
    chk("dc_s0_stall", y, 2'd0);

    a_drv = 2'd2; {i2, i1, i0} = 3'b011;
    tick();
    chk("stall_s2", y, 2'd2);
    a_drv = 2'd2; {i2, i1, i0} = 3'b100;
    tick();
    chk("adv_s2", y, 2'd0);

    // Illegal code with every enable combination, each from a nonzero y.
    for (int k = 0; k < 8; k++) begin
      a_drv = 2'd1; {i2, i1, i0} = 3'b000;
      tick();
      chk($sformatf("pre_illegal_%0d", k), y, 2'd1);
      a_drv = 2'd3; {i2, i1, i0} = 3'(k);
      tick();
      chk($sformatf("illegal_%0d", k), y, 2'd0);
`ifdef FSM_ERR_EN
      chk($sformatf("illegal_err_%0d", k), {1'b0, err}, 2'd1);
`endif
    end

    // Legal code after illegal clears the flag.
    a_drv = 2'd0; {i2, i1, i0} = 3'b001;
    tick();
    chk("post_illegal_y", y, 2'd1);
`ifdef FSM_ERR_EN
    chk("post_illegal_err", {1'b0, err}, 2'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
